fsm_input_cond: RTL and testbench

Input conditioning stage directly upstream of the INIT/RUN/WAIT control FSM. Takes the raw, asynchronous board inputs (start button, stop button, mode switch), synchronises and debounces each, and produces the clean `start`, `stop` and `mode` signals the FSM consumes. `start` and `stop` are single-cycle pulses, one per debounced press; `mode` is a debounced level.

---
 rtl/fsm_pkg.sv | 30 +++
 rtl/fsm_input_cond_debounce.sv | 68 ++++++
 rtl/fsm_input_cond.sv | 78 +++++++
 tb/tb_fsm_input_cond.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// fsm_pkg
// Shared definitions for the INIT/RUN/WAIT control FSM and the input
// conditioning stage that feeds it.
//
// Contents:
//   fsm_state_t            - control FSM state encoding (INIT/RUN/WAIT)
//   DEBOUNCE_CYCLES_SIM    - debounce length used in simulation
//   DEBOUNCE_CYCLES_BOARD  - debounce length used by the board build
//   debounce_cnt_w()       - counter width needed for a given debounce length
package fsm_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } fsm_state_t;

    // Short enough to keep simulation fast while still exercising the
    // counter through several values.
    localparam int DEBOUNCE_CYCLES_SIM   = 4;

    // Roughly 1 ms of settling at a 50 MHz system clock.
    localparam int DEBOUNCE_CYCLES_BOARD = 50000;

    // Width able to hold 0 .. debounce_cycles.
    function automatic int debounce_cnt_w(input int debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/fsm_input_cond_debounce.sv
// debounce
// One conditioning channel: two-flop synchroniser, debounce counter,
// debounced level and a rising-edge pulse.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive cycles the synchronised input must differ
//                     from the stable value before the change is accepted
//                     (must be >= 1)
//   CNT_W           - counter width, derived from DEBOUNCE_CYCLES
//
// Ports:
//   clk   in  1  system clock, rising edge
//   rst   in  1  asynchronous, active-high reset
//   din   in  1  raw asynchronous input
//   level out 1  debounced level
//   rise  out 1  one-cycle pulse on each debounced rising edge
module debounce
    import fsm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
    parameter int CNT_W           = debounce_cnt_w(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             stable;
    logic             prev;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            prev   <= 1'b0;
            cnt    <= '0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= stable;

            // Any cycle of agreement restarts the count, so a glitch shorter
            // than DEBOUNCE_CYCLES never reaches stable. The counter stops at
            // CNT_LAST and is cleared on acceptance, so it cannot wrap.
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Both terms are flops, so the pulse is glitch-free.
    assign level = stable;
    assign rise  = stable & ~prev;

endmodule

// File: rtl/fsm_input_cond.sv
// fsm_input_cond
// Input conditioning stage in front of the INIT/RUN/WAIT control FSM.
// Synchronises and debounces the raw board inputs and presents clean
// start/stop pulses and a debounced mode level.
//
// Parameters:
//   DEBOUNCE_CYCLES - debounce length in cycles (>= 1)
//   CNT_W           - debounce counter width, derived; do not override
//
// Ports:
//   clk       in  1  system clock, rising edge
//   rst       in  1  asynchronous, active-high reset
//   btn_start in  1  raw start button, active-high
//   btn_stop  in  1  raw stop button, active-high
//   sw_mode   in  1  raw mode switch level
//   start     out 1  one-cycle pulse per debounced start press
//   stop      out 1  one-cycle pulse per debounced stop press
//   mode      out 1  debounced mode switch level
module fsm_input_cond
    import fsm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
    parameter int CNT_W           = debounce_cnt_w(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_start,
    input  logic btn_stop,
    input  logic sw_mode,
    output logic start,
    output logic stop,
    output logic mode
);

    // The unused half of each channel (level for buttons, rise for the
    // switch) is left for synthesis to trim.
    logic start_level;
    logic stop_level;
    logic mode_rise;

    debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_start (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_start),
        .level (start_level),
        .rise  (start)
    );

    debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_stop (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_stop),
        .level (stop_level),
        .rise  (stop)
    );

    // Mode is a level: both edges are accepted and no pulse is generated.
    debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_mode (
        .clk   (clk),
        .rst   (rst),
        .din   (sw_mode),
        .level (mode),
        .rise  (mode_rise)
    );

    logic unused_ok;
    assign unused_ok = start_level ^ stop_level ^ mode_rise;

endmodule

// File: tb/tb_fsm_input_cond.sv
// Bench for fsm_input_cond with the default debounce length.
module tb_fsm_input_cond;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_start = 1'b0;
    logic btn_stop  = 1'b0;
    logic sw_mode   = 1'b0;
    logic start, stop, mode;

    int vectors = 0;
    int miscompares = 0;

    fsm_input_cond dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_stop  (btn_stop),
        .sw_mode   (sw_mode),
        .start     (start),
        .stop      (stop),
        .mode      (mode)
    );

    always #5 clk = ~clk;

    // Edge index: incremented on every rising clock edge.
    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Behavioural model. A channel's accepted level flips when the
    // synchronised input (the raw input delayed by two edges) has shown the
    // opposite level at each of the last D edges.
    bit m_s1 [3] = '{0, 0, 0};
    bit m_s2 [3] = '{0, 0, 0};
    bit m_stable [3] = '{0, 0, 0};
    bit m_prev [3] = '{0, 0, 0};
    bit hist [3][$];

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int c = 0; c < 3; c++) begin
                    m_s1[c] = 0; m_s2[c] = 0; m_stable[c] = 0; m_prev[c] = 0;
                    hist[c].delete();
                end
            end else begin
                bit raw [3];
                raw[0] = btn_start; raw[1] = btn_stop; raw[2] = sw_mode;
                for (int c = 0; c < 3; c++) begin
                    bit flip;
                    hist[c].push_back(m_s2[c]);
                    if (hist[c].size() > D) void'(hist[c].pop_front());
                    flip = (hist[c].size() == D);
                    foreach (hist[c][e]) if (hist[c][e] == m_stable[c]) flip = 0;
                    m_prev[c] = m_stable[c];
                    if (flip) m_stable[c] = ~m_stable[c];
                    m_s2[c] = m_s1[c];
                    m_s1[c] = raw[c];
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t edge=%0d)", name, act, exp, $time, edge_n);
        end
    endtask

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            chk("start_model", int'(start), int'(m_stable[0] & ~m_prev[0]));
            chk("stop_model",  int'(stop),  int'(m_stable[1] & ~m_prev[1]));
            chk("mode_model",  int'(mode),  int'(m_stable[2]));
        end
    end

    // Pulse counters and the edge after which each output was seen.
    int start_cnt = 0, stop_cnt = 0;
    int start_edge = -1, stop_edge = -1, mode_edge = -1;
    logic mode_q = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (start === 1'b1) begin start_cnt++; start_edge = edge_n; end
            if (stop === 1'b1) begin stop_cnt++; stop_edge = edge_n; end
            if (mode === 1'b1 && mode_q !== 1'b1) mode_edge = edge_n;
            mode_q = mode;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int k, n0, n1;
    int run_len [6] = '{1, 1, 2, 2, 3, 3};

    initial begin
        // Reset
        tick(3);
        #1;
        chk("reset_start", int'(start), 0);
        chk("reset_stop",  int'(stop),  0);
        chk("reset_mode",  int'(mode),  0);
        @(negedge clk);
        rst = 1'b0;
        tick(6);
        chk("idle_pulses", start_cnt + stop_cnt, 0);

        // Clean press
        @(negedge clk);
        k = edge_n + 1;
        n0 = start_cnt;
        btn_start = 1'b1;
        tick(20);
        btn_start = 1'b0;
        tick(12);
        chk("clean_count", start_cnt - n0, 1);
        chk("clean_edge", start_edge, k + 5);

        // Bounce on stop
        n0 = stop_cnt;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            btn_stop = (i % 2 == 0);
            tick(run_len[i] - 1);
        end
        @(negedge clk);
        k = edge_n + 1;
        btn_stop = 1'b1;
        tick(4);
        chk("bounce_nopulse", stop_cnt - n0, 0);
        tick(8);
        chk("bounce_count", stop_cnt - n0, 1);
        chk("bounce_edge", stop_edge, k + 5);
        btn_stop = 1'b0;
        tick(12);
        chk("bounce_release", stop_cnt - n0, 1);

        // Simultaneous start/stop/mode
        @(negedge clk);
        k = edge_n + 1;
        n0 = start_cnt;
        n1 = stop_cnt;
        btn_start = 1'b1;
        btn_stop  = 1'b1;
        sw_mode   = 1'b1;
        tick(10);
        chk("sim_start_edge", start_edge, k + 5);
        chk("sim_stop_edge",  stop_edge,  k + 5);
        chk("sim_mode_edge",  mode_edge,  k + 5);
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        tick(12);
        chk("sim_start_count", start_cnt - n0, 1);
        chk("sim_stop_count",  stop_cnt - n1,  1);
        chk("sim_mode_held",   int'(mode), 1);

        // Asynchronous reset mid-cycle clears mode immediately
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_reset_mode", int'(mode), 0);
        sw_mode = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick(8);
        chk("post_reset_mode", int'(mode), 0);

        // Reset in the middle of the count
        @(negedge clk);
        k = edge_n + 1;
        n0 = start_cnt;
        btn_start = 1'b1;
        tick(4);
        rst = 1'b1;
        #1;
        chk("midcount_nopulse", start_cnt - n0, 0);
        @(negedge clk);
        rst = 1'b0;
        k = edge_n + 1;
        tick(10);
        chk("midcount_count", start_cnt - n0, 1);
        chk("midcount_edge", start_edge, k + 5);
        btn_start = 1'b0;
        tick(12);
        chk("midcount_release", start_cnt - n0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
